// File: rtl/mdu_hilo.sv
// mdu_hilo: E-stage multiply/divide unit owning the HI/LO registers.
// A down-counter models multi-cycle MULT/DIV latency and drives Busy.
// Optional feature macro: MDU_FLUSH_EN adds a Flush input that aborts an
// in-flight operation.
module mdu_hilo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       MDUOP,
  input  logic [CNTW-1:0]  Time,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ReadHILO,
`ifdef MDU_FLUSH_EN
  input  logic             Flush,
`endif
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] MDUOut
);

  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] phi_q, phi_d;
  logic [WIDTH-1:0] plo_q, plo_d;
  logic             pv_q, pv_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;

  logic             flush_c;
  logic             accept_c;
  logic [PW-1:0]    prod_s_c, prod_u_c;
  logic [WIDTH-1:0] div_b_c;
  logic signed [WIDTH-1:0] quo_s_c, rem_s_c;
  logic [WIDTH-1:0] quo_u_c, rem_u_c;
  logic [WIDTH-1:0] res_hi_c, res_lo_c;
  logic             res_v_c;
  logic             is_md_c;

`ifdef MDU_FLUSH_EN
  assign flush_c = Flush;
`else
  assign flush_c = 1'b0;
`endif

  // A flush in the same cycle discards any Start.
  assign accept_c = Start && !busy_q && !flush_c;

  // Arithmetic datapath; divisor forced nonzero so a zero divide never yields X.
  always_comb begin
    prod_s_c = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    prod_u_c = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    div_b_c  = (B == '0) ? WIDTH'(1) : B;
    quo_s_c  = $signed(A) / $signed(div_b_c);
    rem_s_c  = $signed(A) % $signed(div_b_c);
    if ((A == INT_MIN) && (&B)) begin
      quo_s_c = $signed(INT_MIN);
      rem_s_c = '0;
    end
    quo_u_c  = A / div_b_c;
    rem_u_c  = A % div_b_c;
  end

  // Select the pending result and its validity for the accepted op.
  always_comb begin
    res_hi_c = '0;
    res_lo_c = '0;
    res_v_c  = 1'b1;
    is_md_c  = 1'b0;
    case (MDUOP)
      OP_MULT:  begin is_md_c = 1'b1; {res_hi_c, res_lo_c} = prod_s_c; end
      OP_MULTU: begin is_md_c = 1'b1; {res_hi_c, res_lo_c} = prod_u_c; end
      OP_DIV: begin
        is_md_c  = 1'b1;
        res_lo_c = quo_s_c;
        res_hi_c = rem_s_c;
        res_v_c  = (B != '0);
      end
      OP_DIVU: begin
        is_md_c  = 1'b1;
        res_lo_c = quo_u_c;
        res_hi_c = rem_u_c;
        res_v_c  = (B != '0);
      end
      default: ;
    endcase
  end

  // Next-state: flush, accept, or count down toward commit.
  always_comb begin
    cnt_d = cnt_q;
    phi_d = phi_q;
    plo_d = plo_q;
    pv_d  = pv_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (flush_c) begin
      if (busy_q) begin
        cnt_d = '0;
        pv_d  = 1'b0;
      end
    end else if (accept_c) begin
      if (MDUOP == OP_MTHI) begin
        hi_d = A;
      end else if (MDUOP == OP_MTLO) begin
        lo_d = A;
      end else if (is_md_c) begin
        phi_d = res_hi_c;
        plo_d = res_lo_c;
        pv_d  = res_v_c;
        cnt_d = Time;
        if ((Time == '0) && res_v_c) begin
          hi_d = res_hi_c;
          lo_d = res_lo_c;
        end
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNTW'(1);
      if ((cnt_q == CNTW'(1)) && pv_q) begin
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end
    busy_d = (cnt_d != '0);
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
      pv_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
      pv_q   <= pv_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

  // HI/LO read mux feeding the E-stage result select.
  always_comb begin
    case (ReadHILO)
      2'd1:    MDUOut = hi_q;
      2'd2:    MDUOut = lo_q;
      default: MDUOut = '0;
    endcase
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit in the E stage of the P6 five-stage MIPS pipeline.
- Directly downstream of the control decoder: it consumes Start, MDUOP and Time, plus the forwarded rs/rt operands.
- Owns the architectural HI/LO registers and models a multi-cycle latency with a down-counter.
- Drives Busy to the hazard unit and a selected HI/LO read value to the E-stage result mux.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNTW, 4, width of the Time input and of the latency counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse; qualifies MDUOP for the op in E.
- MDUOP  input  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7-15 treated as none.
- Time  input  CNTW  latency in cycles for ops 1-4.
- A  input  WIDTH  rs operand, forwarded.
- B  input  WIDTH  rt operand, forwarded.
- ReadHILO  input  2  0 selects zero, 1 selects HI, 2 selects LO, 3 selects zero.
- Busy  output  1  high while a MULT/DIV is in flight.
- HI  output  WIDTH  architectural HI register.
- LO  output  WIDTH  architectural LO register.
- MDUOut  output  WIDTH  value selected by ReadHILO (combinational from HI/LO).

Behaviour:
- Reset: while reset=0, asynchronously clear HI, LO, the counter, the pending registers (PHI/PLO), the pending-valid flag and Busy.
- Accept condition: an op is accepted on a rising edge when Start=1 and Busy=0. If Start=1 and Busy=1, the op is ignored with no state change (the hazard unit guarantees this never occurs; this rule makes the case defined).
- MTHI/MTLO: accepted op writes A into HI or LO on that edge. Busy stays 0.
- MULT/MULTU on accept: latch the 64-bit product of A and B (signed or unsigned) into {PHI, PLO}.
- DIV/DIVU on accept: latch PLO = quotient and PHI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Signed overflow: DIV with 0x80000000 / 0xFFFFFFFF gives PLO=0x80000000, PHI=0.
- Divide by zero (B=0, DIV or DIVU): pending-valid is cleared, so HI/LO stay unchanged at commit. Busy timing is still honoured.
- Counter on accept of ops 1-4: load Time.
- Time=0: commit {PHI, PLO} to HI/LO on the accept edge itself; Busy never rises.
- Time=N>0: Busy goes high after the accept edge and stays high for exactly N cycles. The counter decrements each edge. On the edge where the counter goes 1→0, HI/LO take PHI/PLO (if pending-valid) and Busy falls.
- Visibility: MDUOut reflects the new HI/LO in the first cycle Busy is low. A MFHI/MFLO stalled on Busy therefore reads the committed value.
- Busy is a registered output: high exactly when counter != 0.
- Reset asserted mid-operation discards the pending result. HI/LO return to 0.
- Operands are sampled only on the accept edge. Changes to A/B while Busy=1 have no effect.

Optional Feature:
- Macro: MDU_FLUSH_EN.
- Defined: adds input port Flush (1 bit).
- Flush=1 on an edge zeroes the counter and clears pending-valid, so HI/LO are unchanged and Busy is 0 after that edge.
- Flush has priority over Start in the same cycle; that Start is discarded.
- Flush has no effect on an idle unit.
- Undefined: no Flush port. An in-flight op always completes.

Test Plan:
- MULT, Time=5: A=0xFFFFFFFE (-2), B=3 → Busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; ReadHILO=2 gives MDUOut=0xFFFFFFFA.
- MULTU, Time=5: A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles. While Busy, HI/LO keep their old values.
- DIV, Time=10: A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV overflow: A=0x80000000, B=-1 → LO=0x80000000, HI=0.
- DIVU divide-by-zero: A=5, B=0 → Busy high for 10 cycles; HI/LO unchanged.
- MTHI A=0x1234 then MTLO A=0x5678 on consecutive cycles → Busy stays 0; HI=0x1234, LO=0x5678 one edge after each. Start during Busy with MTHI → HI unchanged.
- Reset at counter=3 of a MULT → Busy=0, HI=LO=0 immediately.
- With MDU_FLUSH_EN: Flush at counter=2 → Busy=0 next edge, HI/LO unchanged. Flush and Start in the same cycle → no op accepted.
